// File: rtl/conv1_pkg.sv
// Shared definitions for the conv1 front end: image geometry, window count
// and the stream controller state encoding.
package conv1_pkg;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int N_PIX = IMG_W * IMG_H;
  localparam int N_WIN = (IMG_W - 2) * (IMG_H - 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FINISH = 3'd4
  } stream_state_e;

endpackage

// File: rtl/conv1_stream_ctrl_read_pipe.sv
// One-deep read-valid delay between the frame RAM and the line buffer;
// zero-fill slots carry flush pixels, kill drops a read still in flight.
module stream_read_pipe (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_en,
  input  logic zero_fill,
  input  logic kill,
  input  logic rdata,
  output logic valid_out,
  output logic pixel_out
);

  logic vld_q;
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      vld_q  <= rd_en && !kill;
      zero_q <= zero_fill;
    end
  end

  // RAM data arrives one cycle after the strobe, aligned with vld_q
  assign valid_out = vld_q;
  assign pixel_out = vld_q && !zero_q && rdata;

endmodule

// File: rtl/conv1_stream_ctrl.sv
// Frame sequencer: streams one binarised image from the frame RAM into the
// conv1 line buffer, appends flush pixels and waits for all windows.
module conv1_stream_ctrl
  import conv1_pkg::*;
#(
  parameter  int WIDTH        = IMG_W,
  parameter  int HEIGHT       = IMG_H,
  parameter  int KERNEL       = 3,
  parameter  int FLUSH_PIXELS = 1,
  parameter  int DRAIN_MAX    = 16,
  localparam int PIX_TOTAL    = WIDTH * HEIGHT,
  localparam int WIN_TOTAL    = (WIDTH - KERNEL + 1) * (HEIGHT - KERNEL + 1),
  localparam int ADDR_BITS    = $clog2(PIX_TOTAL),
  localparam int CNT_BITS     = $clog2(WIN_TOTAL + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 pause,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_rdata,
  output logic                 valid_out,
  output logic                 pixel_out,
  input  logic                 win_valid,
  output logic [CNT_BITS-1:0]  win_count,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 lb_clear
);

  localparam int FL_BITS = (FLUSH_PIXELS > 0) ? $clog2(FLUSH_PIXELS + 1) : 1;
  localparam int DR_BITS = $clog2(DRAIN_MAX + 1);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(PIX_TOTAL - 1);
  localparam logic [CNT_BITS-1:0]  WIN_FULL  = CNT_BITS'(WIN_TOTAL);
  localparam logic [FL_BITS-1:0]   FL_LAST   = FL_BITS'(FLUSH_PIXELS);
  localparam logic [DR_BITS-1:0]   DR_LOAD   = DR_BITS'(DRAIN_MAX - 1);

  // state     | meaning
  // ST_IDLE   | waiting for start, counters held clear
  // ST_STREAM | raster reads from the frame RAM
  // ST_FLUSH  | last RAM pixel out, then zero flush pixels
  // ST_DRAIN  | waiting for the lagging windows, timer running
  // ST_FINISH | done or err pulse with lb_clear, back to idle
  stream_state_e state, state_nxt;

  logic [ADDR_BITS-1:0] addr;
  logic [FL_BITS-1:0]   flush_cnt;
  logic [DR_BITS-1:0]   drain_tmr;
  logic [CNT_BITS-1:0]  win_cnt, win_cnt_nxt;
  logic                 flush_rd;
  logic                 kill;
  logic                 in_frame;
  logic                 fin_done;
  logic                 fin_err;

  assign busy      = (state != ST_IDLE);
  assign in_frame  = (state == ST_STREAM) || (state == ST_FLUSH) || (state == ST_DRAIN);
  assign kill      = abort && busy;
  assign mem_rd_en = (state == ST_STREAM) && !pause && (addr <= LAST_ADDR);
  assign flush_rd  = (state == ST_FLUSH) && !pause && (flush_cnt != FL_LAST);
  assign mem_addr  = addr;
  assign win_count = win_cnt;

  // saturating; the DRAIN exit decision sees this cycle's window
  assign win_cnt_nxt = (in_frame && win_valid && (win_cnt != WIN_FULL)) ?
                       win_cnt + CNT_BITS'(1) : win_cnt;

  always_comb begin
    state_nxt = state;
    fin_done  = 1'b0;
    fin_err   = 1'b0;
    case (state)
      ST_IDLE:   if (start && !abort) state_nxt = ST_STREAM;
      ST_STREAM: if (mem_rd_en && (addr == LAST_ADDR)) state_nxt = ST_FLUSH;
      ST_FLUSH:  if (flush_cnt == FL_LAST) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (win_cnt_nxt == WIN_FULL) begin
          state_nxt = ST_FINISH;
          fin_done  = 1'b1;
        end else if (drain_tmr == '0) begin
          state_nxt = ST_FINISH;
          fin_err   = 1'b1;
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (kill) begin
      state_nxt = ST_IDLE;
      fin_done  = 1'b0;
      fin_err   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      done     <= 1'b0;
      err      <= 1'b0;
      lb_clear <= 1'b0;
    end else begin
      state    <= state_nxt;
      done     <= fin_done;
      err      <= fin_err;
      lb_clear <= fin_done || fin_err || kill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      flush_cnt <= '0;
      drain_tmr <= '0;
      win_cnt   <= '0;
    end else if (state == ST_IDLE) begin
      addr      <= '0;
      flush_cnt <= '0;
      drain_tmr <= '0;
      win_cnt   <= '0;
    end else begin
      win_cnt <= win_cnt_nxt;
      if (mem_rd_en) addr <= addr + ADDR_BITS'(1);
      if (flush_rd) flush_cnt <= flush_cnt + FL_BITS'(1);
      // down-counter preloaded while flushing, terminal count at zero
      if (state == ST_FLUSH)
        drain_tmr <= DR_LOAD;
      else if ((state == ST_DRAIN) && (drain_tmr != '0))
        drain_tmr <= drain_tmr - DR_BITS'(1);
    end
  end

  stream_read_pipe u_read_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (mem_rd_en || flush_rd),
    .zero_fill (flush_rd),
    .kill      (kill),
    .rdata     (mem_rdata),
    .valid_out (valid_out),
    .pixel_out (pixel_out)
  );

endmodule

// File: tb/tb_conv1_stream_ctrl.sv
// Scoreboard bench for conv1_stream_ctrl with a behavioural frame RAM and
// line-buffer window model.
module tb_conv1_stream_ctrl;
  import conv1_pkg::*;

  localparam int FLUSH_N   = 1;
  localparam int DRAIN_CYC = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, pause = 1'b0;
  logic       mem_rd_en, valid_out, pixel_out, busy, done, err, lb_clear;
  logic       mem_rdata = 1'b0;
  logic       win_valid;
  logic [9:0] mem_addr, win_count;

  always #5 clk = ~clk;

  conv1_stream_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .pause     (pause),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .valid_out (valid_out),
    .pixel_out (pixel_out),
    .win_valid (win_valid),
    .win_count (win_count),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .lb_clear  (lb_clear)
  );

  bit img [0:1023];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= img[mem_addr];

  // line buffer: a window completes at (x>=2,y>=2) and is reported when
  // the following pixel arrives
  logic lb_en = 1'b0, lb_prev = 1'b0, lb_win = 1'b0, stray = 1'b0;
  int   lb_x = 0, lb_y = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || lb_clear) begin
      lb_x <= 0; lb_y <= 0; lb_prev <= 1'b0; lb_win <= 1'b0;
    end else begin
      lb_win <= valid_out && lb_prev && lb_en;
      if (valid_out) begin
        lb_prev <= (lb_x >= 2) && (lb_y >= 2);
        if (lb_x == IMG_W - 1) begin lb_x <= 0; lb_y <= lb_y + 1; end
        else lb_x <= lb_x + 1;
      end
    end
  end
  assign win_valid = lb_win | stray;

  typedef struct { bit d; bit e; bit b; bit cc; int cyc; int cnt; } res_t;
  res_t res_q[$];
  bit   pix_q[$];
  bit   psch [0:2047];
  int   checks = 0, passes = 0, cur_cyc = -1, rd_next = 0;
  res_t mon_r;
  bit   mon_p;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cur_cyc);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_rd_en"}, mem_rd_en, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_valid_out"}, valid_out, 0);
    check({tag, "_pixel_out"}, pixel_out, 0);
    check({tag, "_win_count"}, win_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_lb_clear"}, lb_clear, 0);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (valid_out) begin
      if (pix_q.size() == 0) check("extra_pixel", 1, 0);
      else begin mon_p = pix_q.pop_front(); check("pixel", pixel_out, mon_p); end
    end
    if (busy && pause) check("read_while_paused", mem_rd_en, 0);
    if (mem_rd_en) begin check("rd_addr", mem_addr, rd_next); rd_next++; end
    if (done || err || lb_clear) begin
      if (res_q.size() == 0) check("unexpected_event", 1, 0);
      else begin
        mon_r = res_q.pop_front();
        check("done", done, mon_r.d);
        check("err", err, mon_r.e);
        check("lb_clear", lb_clear, 1);
        check("event_cycle", cur_cyc, mon_r.cyc);
        check("busy_at_event", busy, mon_r.b);
        if (mon_r.cc) check("win_count", win_count, mon_r.cnt);
      end
    end
  end

  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cur_cyc = -1;
      start = noise && (i == 0);
      abort = noise && (i == 0);
      pause = noise && ($urandom_range(0, 1) == 1);
      stray = noise && ($urandom_range(0, 1) == 1);
    end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; pause = 1'b0; stray = 1'b0;
    #1;
    check("idle_busy", busy, 0);
    check("idle_win_count", win_count, 0);
  endtask

  // cycle 0 is the current cycle; start is sampled at its closing edge
  task automatic run_frame(input bit hold, input int pmode, input bit lb_on,
                           input int abort_at, input bit do_rst);
    int reads, last_rd, flush_c, ev, end_c, n_pix, exp_reads, rst_at;
    res_t r;
    for (int c = 0; c < 2048; c++) psch[c] = 1'b0;
    if (pmode == 1) for (int c = 100; c <= 109; c++) psch[c] = 1'b1;
    if (pmode == 2) for (int c = 2; c < 1000; c++) psch[c] = ($urandom_range(0, 9) == 0);
    reads = 0; last_rd = 0;
    for (int c = 1; reads < N_PIX; c++) if (!psch[c]) begin reads++; last_rd = c; end
    flush_c = last_rd + 1;
    while (psch[flush_c]) flush_c++;
    r.d = 1'b0; r.e = 1'b0; r.b = 1'b1; r.cc = 1'b1; r.cnt = 0;
    if (abort_at > 0) begin
      ev = abort_at + 1; r.b = 1'b0; r.cc = 1'b0;
      n_pix = 0;
      for (int c = 1; c < abort_at; c++) if (!psch[c]) n_pix++;
      exp_reads = n_pix + (psch[abort_at] ? 0 : 1);
    end else begin
      n_pix = N_PIX; exp_reads = N_PIX;
      if (lb_on) begin ev = flush_c + 3; r.d = 1'b1; r.cnt = N_WIN; end
      else begin ev = flush_c + 2 + DRAIN_CYC; r.e = 1'b1; end
    end
    r.cyc = ev;
    for (int i = 0; i < n_pix; i++) pix_q.push_back(img[i]);
    if (abort_at == 0) for (int i = 0; i < FLUSH_N; i++) pix_q.push_back(1'b0);
    res_q.push_back(r);
    rst_at = do_rst ? flush_c + 7 : 0;
    end_c  = do_rst ? rst_at + 4 : ev + 1;
    rd_next = 0; cur_cyc = 0;
    start = 1'b1; abort = 1'b0; pause = 1'b0; stray = 1'b0; lb_en = lb_on;
    for (int c = 1; c <= end_c; c++) begin
      @(posedge clk); #1;
      cur_cyc = c;
      start = hold;
      pause = psch[c];
      abort = (c == abort_at);
      if (c == 1) begin
        #1;
        check("busy_c1", busy, 1);
        check("rd_en_c1", mem_rd_en, 1);
        check("addr_c1", mem_addr, 0);
      end
      if (c == 2) begin #1; check("valid_c2", valid_out, 1); end
      if (do_rst && c == rst_at) begin
        res_q.delete();
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
      end
      if (do_rst && c == rst_at + 2) rst_n = 1'b1;
    end
    #1;
    check("busy_after", busy, 0);
    check("pixels_left", pix_q.size(), 0);
    check("results_left", res_q.size(), 0);
    check("read_count", rd_next, exp_reads);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N_PIX; i++) img[i] = ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    idle(4, 1'b1);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) img[y * IMG_W + x] = ((x + y) % 2) == 1;
    run_frame(1'b0, 0, 1'b1, 0, 1'b0);
    run_frame(1'b0, 1, 1'b1, 0, 1'b0);
    fill_random();
    run_frame(1'b0, 2, 1'b1, 0, 1'b0);
    idle(2, 1'b1);
    fill_random();
    run_frame(1'b0, 2, 1'b1, 0, 1'b0);
    run_frame(1'b0, 0, 1'b0, 0, 1'b0);
    idle(2, 1'b1);
    fill_random();
    run_frame(1'b0, 0, 1'b1, 300, 1'b0);
    run_frame(1'b0, 0, 1'b1, 0, 1'b0);
    run_frame(1'b1, 0, 1'b1, 0, 1'b0);
    run_frame(1'b0, 2, 1'b1, 0, 1'b0);
    run_frame(1'b0, 0, 1'b0, 0, 1'b1);
    idle(6, 1'b1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
